// File: rtl/instr_loader_pkg.sv
// Shared encodings and sizes for the instruction loader.
package instr_loader_pkg;
  typedef enum logic [1:0] {
    HDR  = 2'b00,
    DATA = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);
endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface instr_loader_if #(parameter int ADDR_W = 10);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output rx_data, rx_valid,
                  input  rx_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input  rx_data, rx_valid,
                  output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/instr_loader_byte_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid flags the 4th byte.
module instr_loader_byte_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_acc,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [IDX_W-1:0]            idx;
  logic [WORD_BYTES-1:0][7:0]  lanes;
  logic [WORD_BYTES-1:0][7:0]  merged;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      lanes <= '0;
    end else if (byte_acc) begin
      lanes[idx] <= byte_in;
      idx        <= idx + 1'b1;
    end
  end

  // The completed word includes the byte being accepted now, so the
  // consumer can act on the same edge that takes the last byte.
  always_comb begin
    merged      = lanes;
    merged[idx] = byte_in;
    word        = merged;
    word_valid  = byte_acc && (idx == IDX_W'(WORD_BYTES - 1));
  end
endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian program from a byte stream into instruction memory.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic           clk,
  input  logic           rst,
  instr_loader_if.slave  bus,
  output logic           instrWriteDone,
  output logic           load_error
);
  localparam int CNT_W = ADDR_W + 1;

  state_e             state, state_nxt;
  logic               byte_acc;
  logic [31:0]        word;
  logic               word_valid;
  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   words_written;
  logic               last_word;

  assign bus.rx_ready   = (state == HDR) || (state == DATA);
  assign byte_acc       = bus.rx_valid && bus.rx_ready;
  assign last_word      = (words_written == n_words - CNT_W'(1));
  assign instrWriteDone = (state == DONE);
  assign load_error     = (state == ERR);

  instr_loader_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (bus.rx_data),
    .byte_acc   (byte_acc),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HDR: if (word_valid) begin
        if (word == 32'd0)                 state_nxt = DONE;
        else if (word > 32'(MAX_WORDS))    state_nxt = ERR;
        else                               state_nxt = DATA;
      end
      DATA: if (bus.imem_we && last_word)  state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR;
      bus.imem_we   <= 1'b0;
      bus.imem_addr <= ADDR_W'(BASE_ADDR);
      bus.imem_wdata<= '0;
      n_words       <= '0;
      words_written <= '0;
    end else begin
      state       <= state_nxt;
      bus.imem_we <= (state == DATA) && word_valid;
      if ((state == DATA) && word_valid) begin
        bus.imem_addr  <= ADDR_W'(BASE_ADDR) + words_written[ADDR_W-1:0];
        bus.imem_wdata <= word;
      end
      // Header already bounded by MAX_WORDS, so the low CNT_W bits hold N.
      if ((state == HDR) && word_valid) n_words <= word[CNT_W-1:0];
      if (bus.imem_we) words_written <= words_written + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Directed checks of instr_loader: header handling, word writes, gaps, reset and post-done traffic.
module tb_instr_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instrWriteDone, load_error;

  instr_loader_if #(.ADDR_W(10)) bus_if ();

  instr_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .instrWriteDone (instrWriteDone),
    .load_error     (load_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_acc = 0;
  int done_cyc = -1, err_cyc = -1, b2b = 0;
  logic prev_we = 1'b0;
  logic [31:0] wr_addr[$], wr_data[$];
  int wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus_if.imem_we) begin
      wr_addr.push_back(32'(bus_if.imem_addr));
      wr_data.push_back(bus_if.imem_wdata);
      wr_cyc.push_back(cyc);
      if (prev_we) b2b++;
    end
    prev_we = bus_if.imem_we;
    if (instrWriteDone && done_cyc < 0) done_cyc = cyc;
    if (load_error && err_cyc < 0) err_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cyc = -1; err_cyc = -1; b2b = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(posedge clk); #1;
    last_acc = cyc;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) send_byte(t[8*i +: 8], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    idle(2);
    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(bus_if.rx_ready), 32'd1);
    chk("rst_we",    32'(bus_if.imem_we),  32'd0);
    chk("rst_addr",  32'(bus_if.imem_addr), 32'd0);
    chk("rst_wdata", bus_if.imem_wdata,    32'd0);
    chk("rst_done",  32'(instrWriteDone),  32'd0);
    chk("rst_err",   32'(load_error),      32'd0);

    // Two-word program, back-to-back bytes.
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    idle(3);
    chk("t1_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t1_a0", wr_addr[0], 32'd0);
      chk("t1_d0", wr_data[0], 32'h0000_0013);
      chk("t1_a1", wr_addr[1], 32'd1);
      chk("t1_d1", wr_data[1], 32'h0010_0093);
      chk("t1_lat", 32'(wr_cyc[1]), 32'(last_acc));
      chk("t1_done_cyc", 32'(done_cyc), 32'(wr_cyc[1] + 1));
    end
    chk("t1_done",  32'(instrWriteDone),  32'd1);
    chk("t1_ready", 32'(bus_if.rx_ready), 32'd0);

    // Extra traffic after completion is dropped.
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 0);
    idle(2);
    chk("t6_nwr",  32'(wr_addr.size()), 32'd2);
    chk("t6_done", 32'(instrWriteDone), 32'd1);
    chk("t6_b2b",  32'(b2b), 32'd0);

    // Empty program.
    do_reset();
    send_word(32'd0, 0);
    idle(2);
    chk("t2_nwr",  32'(wr_addr.size()), 32'd0);
    chk("t2_done_cyc", 32'(done_cyc), 32'(last_acc));
    chk("t2_done", 32'(instrWriteDone), 32'd1);

    // Oversize header: MAX_WORDS+1.
    do_reset();
    send_word(32'd1025, 0);
    idle(2);
    chk("t3_err_cyc", 32'(err_cyc), 32'(last_acc));
    chk("t3_err",   32'(load_error),      32'd1);
    chk("t3_ready", 32'(bus_if.rx_ready), 32'd0);
    chk("t3_done",  32'(instrWriteDone),  32'd0);
    send_word(32'h1111_2222, 0);
    idle(2);
    chk("t3_nwr",   32'(wr_addr.size()), 32'd0);

    // Header whose only set bits lie above the count width must still error.
    do_reset();
    send_word(32'h0100_0000, 0);
    idle(2);
    chk("t3b_err",  32'(load_error), 32'd1);

    // N == MAX_WORDS is legal: stays accepting data.
    do_reset();
    send_word(32'd1024, 0);
    idle(2);
    chk("t3c_err",   32'(load_error),      32'd0);
    chk("t3c_ready", 32'(bus_if.rx_ready), 32'd1);

    // Single word with gaps of 0..7 idle cycles between bytes.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h01 : 8'h00, i);
    send_byte(8'hEF, 4);
    send_byte(8'hBE, 5);
    send_byte(8'hAD, 6);
    send_byte(8'hDE, 7);
    idle(3);
    chk("t4_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t4_a0", wr_addr[0], 32'd0);
      chk("t4_d0", wr_data[0], 32'hDEAD_BEEF);
    end
    chk("t4_done", 32'(instrWriteDone), 32'd1);

    // Reset in the middle of word 1 of a three-word load.
    do_reset();
    send_word(32'd3, 0);
    send_word(32'h0000_0013, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    idle(1);
    chk("t5_pre_nwr", 32'(wr_addr.size()), 32'd1);
    do_reset();
    @(negedge clk);
    chk("t5_done", 32'(instrWriteDone),   32'd0);
    chk("t5_addr", 32'(bus_if.imem_addr), 32'd0);
    send_word(32'd1, 0);
    send_word(32'h4433_2211, 0);
    idle(3);
    chk("t5_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t5_a0", wr_addr[0], 32'd0);
      chk("t5_d0", wr_data[0], 32'h4433_2211);
    end
    chk("t5_done2", 32'(instrWriteDone), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
